// File: rtl/mdio_master_if.sv
// mdio_master_if: request/response handshake between the framing register block and mdio_master
// Signals: req_valid/req_ready handshake, req_write, req_phy_addr, req_reg_addr, req_wdata request fields;
//          rsp_valid pulse with rsp_rdata; busy while a frame runs; rsp_err when MDIO_TA_CHECK_EN is defined.
// Modports: master = requester, slave = mdio_master.
interface mdio_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [4:0]  req_phy_addr;
   logic [4:0]  req_reg_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        busy;
`ifdef MDIO_TA_CHECK_EN
   logic        rsp_err;
   modport master (output req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata,
                   input req_ready, rsp_valid, rsp_rdata, busy, rsp_err);
   modport slave  (input req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata, busy, rsp_err);
`else
   modport master (output req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata,
                   input req_ready, rsp_valid, rsp_rdata, busy);
   modport slave  (input req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata, busy);
`endif
endinterface

// File: rtl/mdio_master.sv
// mdio_master: Clause 22 MDIO management master running a full read/write frame per request
// Ports: msoc_clk clock; rst_int asynchronous active-high reset; bus (mdio_master_if.slave) request/response
//        handshake and busy; phy_mdio_i/phy_mdio_o/phy_mdio_oe MDIO pad; phy_mdc MDC.
// Optional: define MDIO_TA_CHECK_EN to add bus.rsp_err, set on reads where no PHY pulled the second TA bit low.
module mdio_master #(
   parameter int CLK_DIV      = 25,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic         msoc_clk,
   input  logic         rst_int,
   mdio_master_if.slave bus,
   input  logic         phy_mdio_i,
   output logic         phy_mdio_o,
   output logic         phy_mdio_oe,
   output logic         phy_mdc
);
   typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [5:0] PRE_LAST = 6'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic          ph_q, ph_d;
   logic [5:0]    bit_q, bit_d;
   logic [31:0]   sh_q, sh_d;
   logic [15:0]   rd_q, rd_d, rdata_q, rdata_d;
   logic          wr_q, wr_d;
   logic          in_frame, wrap, rise, fall, last;
`ifdef MDIO_TA_CHECK_EN
   logic          ta_q, ta_d, err_q, err_d;
`endif
   // ph_q is the MDC phase: 0 for the first half of a bit, 1 for the second
   assign in_frame    = state_q inside {PRE, HDR, TA, DATA};
   assign wrap        = div_q == DIV_MAX;
   assign rise        = in_frame & ~ph_q & wrap;
   assign fall        = in_frame & ph_q & wrap;
   assign last        = fall & (bit_q == 6'd0);
   assign phy_mdc     = in_frame & ph_q;
   assign phy_mdio_oe = (state_q inside {PRE, HDR}) | ((state_q inside {TA, DATA}) & wr_q);
   // sh_q[31] is the current bit after the preamble; a released line idles high
   assign phy_mdio_o  = (phy_mdio_oe & (state_q != PRE)) ? sh_q[31] : 1'b1;
   assign bus.req_ready = state_q == IDLE;
   assign bus.busy      = state_q != IDLE;
   assign bus.rsp_valid = state_q == DONE;
   assign bus.rsp_rdata = rdata_q;
`ifdef MDIO_TA_CHECK_EN
   assign bus.rsp_err   = err_q;
`endif
   always_comb begin
      state_d = state_q;
      div_d   = (in_frame & ~wrap) ? div_q + DW'(1) : '0;
      ph_d    = in_frame & (ph_q ^ wrap);
      bit_d   = fall ? bit_q - 6'd1 : bit_q;
      sh_d    = (fall & (state_q != PRE)) ? {sh_q[30:0], 1'b1} : sh_q;
      rd_d    = (rise & (state_q == DATA)) ? {rd_q[14:0], phy_mdio_i} : rd_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
`ifdef MDIO_TA_CHECK_EN
      ta_d    = (rise & (state_q == TA) & (bit_q == 6'd0)) ? phy_mdio_i : ta_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: if (bus.req_valid) begin
            wr_d    = bus.req_write;
            sh_d    = {2'b01, bus.req_write ? 2'b01 : 2'b10, bus.req_phy_addr, bus.req_reg_addr, 2'b10,
                       bus.req_write ? bus.req_wdata : 16'hFFFF};
            state_d = (PREAMBLE_LEN > 0) ? PRE : HDR;
            bit_d   = (PREAMBLE_LEN > 0) ? PRE_LAST : 6'd13;
         end
         PRE: if (last) begin
            state_d = HDR;
            bit_d   = 6'd13;
         end
         HDR: if (last) begin
            state_d = TA;
            bit_d   = 6'd1;
         end
         TA: if (last) begin
            state_d = DATA;
            bit_d   = 6'd15;
         end
         DATA: if (last) begin
            state_d = DONE;
`ifdef MDIO_TA_CHECK_EN
            rdata_d = wr_q ? 16'h0 : (ta_q ? 16'hFFFF : rd_q);
            err_d   = ~wr_q & ta_q;
`else
            rdata_d = wr_q ? 16'h0 : rd_q;
`endif
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge msoc_clk or posedge rst_int) begin
      if (rst_int) begin
         state_q <= IDLE;
         div_q   <= '0;
         ph_q    <= 1'b0;
         bit_q   <= 6'd0;
         sh_q    <= '1;
         rd_q    <= '0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
`ifdef MDIO_TA_CHECK_EN
         ta_q    <= 1'b0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
`ifdef MDIO_TA_CHECK_EN
         ta_q    <= ta_d;
         err_q   <= err_d;
`endif
      end
   end
endmodule
